tcam_match_encoder: RTL and testbench
=====================================

Name: tcam_match_encoder

Overview:
- Downstream stage of the TCAM lookup array; consumes its per-entry match vector (bit i = entry i matched).
- Captures one vector per lookup and serialises the set bits into entry addresses, lowest index first, one per valid/ready handshake.
- Reports a match count, miss and last-address flags, and can be told to report only the highest-priority (lowest-index) hit.
- Feeds address-indexed consumers such as the action/data RAM.

Parameters:
- MEMORY_SIZE, 32, number of TCAM entries (width of match vector); must be >= 2.
- ADDR_W, $clog2(MEMORY_SIZE), width of an entry address.
- CNT_W, $clog2(MEMORY_SIZE)+1, width of match count (holds 0..MEMORY_SIZE).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- matched  input  MEMORY_SIZE  match vector from the TCAM.
- match_valid  input  1  matched is valid this cycle.
- first_only  input  1  sampled with matched: report only the lowest-index hit.
- in_ready  output  1  block can accept a vector this cycle.
- addr_valid  output  1  addr/miss/last/match_count hold a response.
- out_ready  input  1  consumer accepts the current response.
- addr  output  ADDR_W  matching entry index; 0 when miss.
- miss  output  1  response is "no entry matched".
- last  output  1  final response for the current lookup.
- match_count  output  CNT_W  popcount of the captured vector (before first_only pruning).

Behaviour:
- One clock domain. Reset is synchronous, active-high, on clk. Reset has priority over every other event, including mid-scan: it discards the pending vector.
- Reset values: state=IDLE, in_ready=1, addr_valid=0, addr=0, miss=0, last=0, match_count=0, pending vector=0.
- State machine:
  - IDLE: in_ready=1, addr_valid=0. Capture happens when match_valid=1 at a clock edge. At capture:
    - pending <= matched, or only its lowest set bit if first_only=1.
    - match_count <= popcount(matched).
    - Next state: MISS if matched==0, else SCAN.
  - MISS: addr_valid=1, miss=1, last=1, addr=0. On out_ready=1 go to IDLE.
  - SCAN: addr_valid=1, miss=0.
    - addr = index of lowest set bit of pending.
    - last = 1 when pending has exactly one set bit.
    - On out_ready=1 clear that bit of pending. If last=1, go to IDLE.
- Latency: the first response is visible the cycle after capture. Each subsequent address is visible the cycle after the previous handshake. Throughput is one address per cycle while out_ready is held high.
- in_ready=1 only in IDLE. It is a function of state only, with no combinational path from match_valid. match_valid while in_ready=0 is ignored and the vector is lost; the upstream controller must wait for in_ready.
- addr, miss, last and match_count derive from registered state only, with no combinational path from any input. They are held stable while addr_valid=1 and out_ready=0.
- match_count holds its value after returning to IDLE until the next capture.
- An address is never emitted twice per lookup. Addresses are emitted in strictly ascending order.
- Boundaries:
  - All-ones vector: MEMORY_SIZE responses, last only on index MEMORY_SIZE-1, match_count=MEMORY_SIZE.
  - Only bit MEMORY_SIZE-1 set: a single response, addr=MEMORY_SIZE-1, last=1.
  - first_only with zero vector: MISS response.
- Back-to-back lookups: the earliest next capture is the cycle after the last handshake, since the block is in IDLE that cycle. Minimum period per lookup = hits+1 cycles (2 for a miss).

Test Plan:
- Reset then idle: reset=1 for 2 cycles mid-activity, then release → in_ready=1, addr_valid=0, match_count=0. Inject reset during a SCAN of 0x0000_00F0 → next cycle IDLE with no further responses.
- Multi-hit serialisation: matched=0x8000_0105, first_only=0, out_ready=1 → responses on consecutive cycles:
  - addr 0, 2, 8, 31.
  - last=1 only on 31.
  - match_count=4 throughout.
  - in_ready returns to 1 the cycle after addr 31.
- Back-pressure: matched=0x0000_0030, out_ready low for 3 cycles then high → addr=4 held stable for 3 cycles, then 4, 5 accepted. match_valid pulsed while busy is ignored.
- Miss: matched=0 → one response with miss=1, last=1, addr=0, match_count=0. Then IDLE.
- first_only: matched=0x0001_1000, first_only=1 → single response addr=12, last=1, match_count=2.
- Boundaries and throughput:
  - matched=0xFFFF_FFFF → 32 ascending responses, last on 31, match_count=32.
  - matched=0x8000_0000 → addr=31, last=1.
  - Two lookups issued as soon as in_ready=1 → no lost or duplicated addresses.

Source files
------------

// File: rtl/tcam_match_encoder.sv
// Serialises a captured TCAM match vector into ascending entry addresses,
// one per valid/ready handshake, with miss/last flags and a hit count.
module tcam_match_encoder #(
    parameter int MEMORY_SIZE = 32,
    parameter int ADDR_W      = $clog2(MEMORY_SIZE),
    parameter int CNT_W       = $clog2(MEMORY_SIZE) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MEMORY_SIZE-1:0] matched,
    input  logic                   match_valid,
    input  logic                   first_only,
    output logic                   in_ready,
    output logic                   addr_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      addr,
    output logic                   miss,
    output logic                   last,
    output logic [CNT_W-1:0]       match_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [MEMORY_SIZE-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]       match_count_q, match_count_d;

    logic [MEMORY_SIZE-1:0] in_lowbit, pend_lowbit;
    logic [CNT_W-1:0]       in_popcnt;
    logic [ADDR_W-1:0]      pend_idx;
    logic                   pend_single;

    // Two's-complement trick isolates the lowest set bit of each vector.
    always_comb begin
        in_lowbit   = matched & (~matched + MEMORY_SIZE'(1));
        pend_lowbit = pending_q & (~pending_q + MEMORY_SIZE'(1));
        pend_single = (pending_q != '0) && ((pending_q & (pending_q - MEMORY_SIZE'(1))) == '0);
        in_popcnt   = '0;
        for (int i = 0; i < MEMORY_SIZE; i++)
            in_popcnt = in_popcnt + CNT_W'(matched[i]);
        pend_idx = '0;
        for (int i = MEMORY_SIZE - 1; i >= 0; i--)
            if (pending_q[i]) pend_idx = ADDR_W'(i);
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        match_count_d = match_count_q;
        case (state_q)
            ST_IDLE: begin
                if (match_valid) begin
                    pending_d     = first_only ? in_lowbit : matched;
                    match_count_d = in_popcnt;
                    state_d       = (matched == '0) ? ST_MISS : ST_SCAN;
                end
            end
            ST_MISS: begin
                if (out_ready) state_d = ST_IDLE;
            end
            ST_SCAN: begin
                if (out_ready) begin
                    pending_d = pending_q & ~pend_lowbit;
                    if (pend_single) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            match_count_q <= match_count_d;
        end
    end

    // All outputs come from registered state only.
    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        addr_valid  = (state_q == ST_MISS) || (state_q == ST_SCAN);
        miss        = (state_q == ST_MISS);
        last        = (state_q == ST_MISS) || ((state_q == ST_SCAN) && pend_single);
        addr        = (state_q == ST_SCAN) ? pend_idx : '0;
        match_count = match_count_q;
    end

endmodule

// File: tb/tb_tcam_match_encoder.sv
// Randomised and directed bench for tcam_match_encoder against a queue-based
// model of the expected address stream per lookup.
module tb_tcam_match_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] matched;
    logic        match_valid;
    logic        first_only;
    logic        in_ready;
    logic        addr_valid;
    logic        out_ready;
    logic [4:0]  addr;
    logic        miss;
    logic        last;
    logic [5:0]  match_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] last_cnt = '0;

    always #5 clk = ~clk;

    tcam_match_encoder #(.MEMORY_SIZE(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .matched    (matched),
        .match_valid(match_valid),
        .first_only (first_only),
        .in_ready   (in_ready),
        .addr_valid (addr_valid),
        .out_ready  (out_ready),
        .addr       (addr),
        .miss       (miss),
        .last       (last),
        .match_count(match_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected stream: ascending set-bit indices (only the lowest when fo),
    // or one miss response for an empty vector.
    task automatic do_lookup(input logic [31:0] vec, input logic fo, input int rdy_pct);
        logic [4:0] q[$];
        logic [5:0] cnt;
        int n, k, cyc;
        q = {};
        cnt = 6'($countones(vec));
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                q.push_back(5'(i));
                if (fo) break;
            end
        end
        n = (q.size() == 0) ? 1 : q.size();
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_addr_valid", 32'(addr_valid), 32'd0);
        chk("idle_cnt_hold", 32'(match_count), 32'(last_cnt));
        matched = vec; first_only = fo; match_valid = 1'b1;
        @(posedge clk);
        k = 0; cyc = 0;
        while (k < n && cyc < 400) begin
            @(negedge clk);
            // Pulses while busy must be ignored.
            matched = $urandom; first_only = 1'($urandom); match_valid = ($urandom_range(0, 3) == 0);
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("addr_valid", 32'(addr_valid), 32'd1);
            chk("match_count", 32'(match_count), 32'(cnt));
            if (q.size() == 0) begin
                chk("miss_flag", 32'(miss), 32'd1);
                chk("miss_last", 32'(last), 32'd1);
                chk("miss_addr", 32'(addr), 32'd0);
            end else begin
                chk("hit_miss", 32'(miss), 32'd0);
                chk("hit_addr", 32'(addr), 32'(q[k]));
                chk("hit_last", 32'(last), 32'(k == n - 1));
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            @(posedge clk);
            if (out_ready) k++;
            cyc++;
        end
        if (k < n) chk("timeout", 32'(k), 32'(n));
        last_cnt = cnt;
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; matched = '0; match_valid = 1'b0; first_only = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_addr_valid", 32'(addr_valid), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_miss", 32'(miss), 32'd0);
        chk("rst_last", 32'(last), 32'd0);

        // Reset mid-scan discards the pending vector.
        matched = 32'h0000_00F0; match_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        match_valid = 1'b0; out_ready = 1'b1;
        chk("pre_rst_addr", 32'(addr), 32'd4);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_addr2", 32'(addr), 32'd5);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_addr_valid", 32'(addr_valid), 32'd0);
        chk("midrst_count", 32'(match_count), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_quiet", 32'(addr_valid), 32'd0);
        end
        last_cnt = '0;

        // Directed cases, then back-to-back random lookups.
        do_lookup(32'h8000_0105, 1'b0, 100);
        do_lookup(32'h0000_0030, 1'b0, 30);
        do_lookup(32'h0000_0000, 1'b0, 100);
        do_lookup(32'h0001_1000, 1'b1, 100);
        do_lookup(32'hFFFF_FFFF, 1'b0, 100);
        do_lookup(32'h8000_0000, 1'b0, 50);
        do_lookup(32'h0000_0000, 1'b1, 100);
        do_lookup(32'hFFFF_FFFF, 1'b0, 40);
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0: v = $urandom;
                1: v = $urandom & $urandom & $urandom;
                2: v = 32'd1 << $urandom_range(0, 31);
                3: v = 32'h0;
                default: v = 32'hFFFF_FFFF;
            endcase
            do_lookup(v, 1'($urandom), ($urandom_range(0, 1) == 1) ? 100 : 50);
        end

        @(negedge clk);
        match_valid = 1'b0; out_ready = 1'b0;
        chk("end_in_ready", 32'(in_ready), 32'd1);
        chk("end_cnt_hold", 32'(match_count), 32'(last_cnt));
        @(negedge clk);
        chk("end_idle", 32'(addr_valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
